// File: rtl/mvm_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mvm_pkg
//  Description : Shared defaults, command codes, byte counts and the state
//                encoding for the MVM UART controller.
//  Revision    : 1.0 - initial release
// ============================================================================
package mvm_pkg;

    // Default geometry of the matrix-vector multiplier
    localparam int MVM_R             = 8;
    localparam int MVM_C             = 8;
    localparam int MVM_W_K           = 4;
    localparam int MVM_W_X           = 4;
    localparam int MVM_W_Y_OUT       = 16;
    localparam int MVM_BITS_PER_WORD = 8;

    // Operand sizes in bytes, as seen on the UART link
    localparam int K_BYTES = MVM_R * MVM_C * MVM_W_K / MVM_BITS_PER_WORD;
    localparam int X_BYTES = MVM_C * MVM_W_X / MVM_BITS_PER_WORD;

    // Command bytes accepted in IDLE
    localparam logic [7:0] CMD_LOAD_KX = 8'h01;
    localparam logic [7:0] CMD_LOAD_X  = 8'h02;

    // Controller states; the serializer reuses IDLE/SEND_LO/SEND_HI
    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_LOAD_K  = 3'd1,
        ST_LOAD_X  = 3'd2,
        ST_START   = 3'd3,
        ST_WAIT    = 3'd4,
        ST_SEND_LO = 3'd5,
        ST_SEND_HI = 3'd6
    } state_e;

endpackage
`default_nettype wire

// File: rtl/mvm_y_serializer.sv
`default_nettype none
// ============================================================================
//  Module      : mvm_y_serializer
//  Description : Walks the Y vector and offers each element to the UART TX
//                as two bytes (low first) with a valid/ready hold. tx_valid
//                drops for one cycle after every transfer while the next
//                byte is latched from the combinational Y read port.
//  Revision    : 1.0 - initial release
// ============================================================================
module mvm_y_serializer
    import mvm_pkg::*;
#(
    parameter int  R             = MVM_R,
    parameter int  W_Y_OUT       = MVM_W_Y_OUT,
    parameter int  BITS_PER_WORD = MVM_BITS_PER_WORD,
    localparam int YW            = $clog2(R)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start_i,
    input  logic                     tx_ready_i,
    input  logic [W_Y_OUT-1:0]       y_data_i,
    output logic [YW-1:0]            y_addr_o,
    output logic                     tx_valid_o,
    output logic [BITS_PER_WORD-1:0] tx_data_o,
    output logic                     lo_xfer_o,
    output logic                     hi_xfer_o,
    output logic                     last_o
);

    state_e                   state_q, state_d;
    logic [YW-1:0]            y_addr_q, y_addr_d;
    logic                     valid_q, valid_d;
    logic [BITS_PER_WORD-1:0] data_q, data_d;

    assign y_addr_o   = y_addr_q;
    assign tx_valid_o = valid_q;
    assign tx_data_o  = data_q;
    assign last_o     = (y_addr_q == YW'(R - 1));

    // State and output registers; reset abandons any byte in flight
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            y_addr_q <= '0;
            valid_q  <= 1'b0;
            data_q   <= '0;
        end else begin
            state_q  <= state_d;
            y_addr_q <= y_addr_d;
            valid_q  <= valid_d;
            data_q   <= data_d;
        end
    end

    // Byte sequencing: latch a byte with valid low, then hold until accepted
    always_comb begin
        state_d   = state_q;
        y_addr_d  = y_addr_q;
        valid_d   = valid_q;
        data_d    = data_q;
        lo_xfer_o = 1'b0;
        hi_xfer_o = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    y_addr_d = '0;
                    valid_d  = 1'b0;
                    state_d  = ST_SEND_LO;
                end
            end
            ST_SEND_LO: begin
                if (!valid_q) begin
                    data_d  = y_data_i[BITS_PER_WORD-1:0];
                    valid_d = 1'b1;
                end else if (tx_ready_i) begin
                    lo_xfer_o = 1'b1;
                    valid_d   = 1'b0;
                    state_d   = ST_SEND_HI;
                end
            end
            ST_SEND_HI: begin
                if (!valid_q) begin
                    data_d  = y_data_i[2*BITS_PER_WORD-1:BITS_PER_WORD];
                    valid_d = 1'b1;
                end else if (tx_ready_i) begin
                    hi_xfer_o = 1'b1;
                    valid_d   = 1'b0;
                    if (last_o) begin
                        state_d = ST_IDLE;
                    end else begin
                        y_addr_d = y_addr_q + 1'b1;
                        state_d  = ST_SEND_LO;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                valid_d = 1'b0;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/mvm_uart_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : mvm_uart_ctrl
//  Description : UART-facing control for a matrix-vector multiplier. Decodes
//                command bytes, streams K/X operand bytes into the MVM
//                buffers, kicks off a compute and returns Y over TX.
//  Revision    : 1.0 - initial release
// ============================================================================
module mvm_uart_ctrl
    import mvm_pkg::*;
#(
    parameter int  R             = MVM_R,
    parameter int  C             = MVM_C,
    parameter int  W_K           = MVM_W_K,
    parameter int  W_X           = MVM_W_X,
    parameter int  W_Y_OUT       = MVM_W_Y_OUT,
    parameter int  BITS_PER_WORD = MVM_BITS_PER_WORD,
    localparam int K_LEN         = R * C * W_K / BITS_PER_WORD,
    localparam int X_LEN         = C * W_X / BITS_PER_WORD,
    localparam int AW            = $clog2(K_LEN),
    localparam int YW            = $clog2(R)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     rx_valid,
    input  logic [BITS_PER_WORD-1:0] rx_data,
    output logic                     ld_valid,
    output logic                     ld_sel,
    output logic [AW-1:0]            ld_addr,
    output logic [BITS_PER_WORD-1:0] ld_data,
    output logic                     mvm_start,
    input  logic                     mvm_done,
    output logic [YW-1:0]            y_addr,
    input  logic [W_Y_OUT-1:0]       y_data,
    output logic                     tx_valid,
    output logic [BITS_PER_WORD-1:0] tx_data,
    input  logic                     tx_ready,
    output logic                     busy,
    output logic                     err,
    output logic                     ovr
);

    state_e                   state_q, state_d;
    logic [AW-1:0]            cnt_q, cnt_d;
    logic                     ld_valid_q, ld_valid_d;
    logic                     ld_sel_q, ld_sel_d;
    logic [AW-1:0]            ld_addr_q, ld_addr_d;
    logic [BITS_PER_WORD-1:0] ld_data_q, ld_data_d;
    logic                     mvm_start_q, mvm_start_d;
    logic                     busy_q, busy_d;
    logic                     err_q, err_d;
    logic                     ovr_q, ovr_d;

    logic                     ser_start;
    logic                     ser_lo_xfer;
    logic                     ser_hi_xfer;
    logic                     ser_last;

    assign ld_valid  = ld_valid_q;
    assign ld_sel    = ld_sel_q;
    assign ld_addr   = ld_addr_q;
    assign ld_data   = ld_data_q;
    assign mvm_start = mvm_start_q;
    assign busy      = busy_q;
    assign err       = err_q;
    assign ovr       = ovr_q;

    mvm_y_serializer #(
        .R             (R),
        .W_Y_OUT       (W_Y_OUT),
        .BITS_PER_WORD (BITS_PER_WORD)
    ) u_ser (
        .clk        (clk),
        .rst        (rst),
        .start_i    (ser_start),
        .tx_ready_i (tx_ready),
        .y_data_i   (y_data),
        .y_addr_o   (y_addr),
        .tx_valid_o (tx_valid),
        .tx_data_o  (tx_data),
        .lo_xfer_o  (ser_lo_xfer),
        .hi_xfer_o  (ser_hi_xfer),
        .last_o     (ser_last)
    );

    // Controller registers; reset wins over any coincident command byte
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            ld_valid_q  <= 1'b0;
            ld_sel_q    <= 1'b0;
            ld_addr_q   <= '0;
            ld_data_q   <= '0;
            mvm_start_q <= 1'b0;
            busy_q      <= 1'b0;
            err_q       <= 1'b0;
            ovr_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            ld_valid_q  <= ld_valid_d;
            ld_sel_q    <= ld_sel_d;
            ld_addr_q   <= ld_addr_d;
            ld_data_q   <= ld_data_d;
            mvm_start_q <= mvm_start_d;
            busy_q      <= busy_d;
            err_q       <= err_d;
            ovr_q       <= ovr_d;
        end
    end

    // Next-state decode, load strobes and sticky error flags
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        ld_valid_d  = 1'b0;
        ld_sel_d    = ld_sel_q;
        ld_addr_d   = ld_addr_q;
        ld_data_d   = ld_data_q;
        mvm_start_d = 1'b0;
        err_d       = err_q;
        ovr_d       = ovr_q;
        ser_start   = 1'b0;

        // Bytes have nowhere to go once the operands are complete
        if (rx_valid && (state_q inside {ST_START, ST_WAIT, ST_SEND_LO, ST_SEND_HI})) begin
            ovr_d = 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                if (rx_valid) begin
                    if (rx_data == CMD_LOAD_KX) begin
                        state_d = ST_LOAD_K;
                        cnt_d   = '0;
                    end else if (rx_data == CMD_LOAD_X) begin
                        state_d = ST_LOAD_X;
                        cnt_d   = '0;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            ST_LOAD_K: begin
                if (rx_valid) begin
                    ld_valid_d = 1'b1;
                    ld_sel_d   = 1'b0;
                    ld_addr_d  = cnt_q;
                    ld_data_d  = rx_data;
                    if (cnt_q == AW'(K_LEN - 1)) begin
                        state_d = ST_LOAD_X;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            ST_LOAD_X: begin
                if (rx_valid) begin
                    ld_valid_d = 1'b1;
                    ld_sel_d   = 1'b1;
                    ld_addr_d  = cnt_q;
                    ld_data_d  = rx_data;
                    if (cnt_q == AW'(X_LEN - 1)) begin
                        state_d = ST_START;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            ST_START: begin
                // Lands one cycle after the final X write strobe
                mvm_start_d = 1'b1;
                state_d     = ST_WAIT;
            end
            ST_WAIT: begin
                if (mvm_done) begin
                    ser_start = 1'b1;
                    state_d   = ST_SEND_LO;
                end
            end
            ST_SEND_LO: begin
                if (ser_lo_xfer) begin
                    state_d = ST_SEND_HI;
                end
            end
            ST_SEND_HI: begin
                if (ser_hi_xfer) begin
                    state_d = ser_last ? ST_IDLE : ST_SEND_LO;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

endmodule
`default_nettype wire

// File: tb/tb_mvm_uart_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mvm_uart_ctrl
//  Description : Self-checking bench for mvm_uart_ctrl with a behavioural
//                MVM model and scoreboard queues for load writes and TX bytes.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mvm_uart_ctrl;

    typedef struct packed {
        logic       sel;
        logic [4:0] addr;
        logic [7:0] data;
    } ld_exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        rx_valid;
    logic [7:0]  rx_data;
    logic        ld_valid;
    logic        ld_sel;
    logic [4:0]  ld_addr;
    logic [7:0]  ld_data;
    logic        mvm_start;
    logic        mvm_done;
    logic [2:0]  y_addr;
    logic [15:0] y_data;
    logic        tx_valid;
    logic [7:0]  tx_data;
    logic        tx_ready;
    logic        busy;
    logic        err;
    logic        ovr;

    logic        model_done;
    logic        stray_done;
    logic [15:0] y_mem [8];

    logic [255:0] k_ref, k_cap;
    logic [31:0]  x_ref, x_cap;

    ld_exp_t     ld_q[$];
    logic [7:0]  tx_q[$];

    int checks = 0;
    int errors = 0;
    int start_cnt = 0;
    int exp_starts = 0;
    int frame_tx_cnt = 0;
    bit prev_xfer = 1'b0;
    bit bp_arm = 1'b0;

    assign mvm_done = model_done | stray_done;
    assign y_data   = y_mem[y_addr];

    always #5 clk = ~clk;

    mvm_uart_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .rx_valid  (rx_valid),
        .rx_data   (rx_data),
        .ld_valid  (ld_valid),
        .ld_sel    (ld_sel),
        .ld_addr   (ld_addr),
        .ld_data   (ld_data),
        .mvm_start (mvm_start),
        .mvm_done  (mvm_done),
        .y_addr    (y_addr),
        .y_data    (y_data),
        .tx_valid  (tx_valid),
        .tx_data   (tx_data),
        .tx_ready  (tx_ready),
        .busy      (busy),
        .err       (err),
        .ovr       (ovr)
    );

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    // Reference product row: 4-bit elements, low nibble first in each byte
    function automatic logic [15:0] y_of(input logic [255:0] kb, input logic [31:0] xb, input int row);
        logic [15:0] s = 16'd0;
        for (int j = 0; j < 8; j++) begin
            s = s + 16'(kb[(row*8+j)*4 +: 4]) * 16'(xb[j*4 +: 4]);
        end
        return s;
    endfunction

    // Monitor: load writes and TX bytes against the scoreboard queues
    always @(negedge clk) begin
        ld_exp_t e;
        if (ld_valid) begin
            if (ld_q.size() == 0) begin
                chk("ld_unexpected", 32'(ld_valid), 32'(0));
            end else begin
                e = ld_q.pop_front();
                chk("ld_sel", 32'(ld_sel), 32'(e.sel));
                chk("ld_addr", 32'(ld_addr), 32'(e.addr));
                chk("ld_data", 32'(ld_data), 32'(e.data));
            end
            if (ld_sel) x_cap[int'(ld_addr[1:0])*8 +: 8] = ld_data;
            else        k_cap[int'(ld_addr)*8 +: 8] = ld_data;
        end
        if (prev_xfer) chk("tx_gap", 32'(tx_valid), 32'(0));
        prev_xfer = tx_valid && tx_ready;
        if (tx_valid && tx_ready) begin
            if (tx_q.size() == 0) begin
                chk("tx_unexpected", 32'(tx_valid), 32'(0));
            end else begin
                chk("tx_data", 32'(tx_data), 32'(tx_q.pop_front()));
            end
            frame_tx_cnt++;
        end
    end

    // MVM model: compute Y from the captured buffers, answer after 5 cycles
    initial begin
        model_done = 1'b0;
        for (int r = 0; r < 8; r++) y_mem[r] = 16'd0;
        forever begin
            @(negedge clk);
            if (mvm_start) begin
                start_cnt++;
                for (int r = 0; r < 8; r++) y_mem[r] = y_of(k_cap, x_cap, r);
                repeat (5) @(posedge clk);
                #1 model_done = 1'b1;
                @(posedge clk);
                #1 model_done = 1'b0;
            end
        end
    end

    // TX sink: stalls 10 cycles on byte index 3 when armed
    initial begin
        tx_ready = 1'b1;
        forever begin
            @(posedge clk); #1;
            if (bp_arm && tx_valid && frame_tx_cnt == 3) begin
                bp_arm   = 1'b0;
                tx_ready = 1'b0;
                for (int i = 0; i < 10; i++) begin
                    @(negedge clk);
                    chk("bp_valid", 32'(tx_valid), 32'(1));
                    chk("bp_data", 32'(tx_data), 32'(tx_q[0]));
                    @(posedge clk); #1;
                end
                tx_ready = 1'b1;
            end
        end
    end

    // Called at posedge+1; returns at posedge+1 one idle cycle later
    task automatic send_byte(input logic [7:0] b);
        rx_valid = 1'b1;
        rx_data  = b;
        @(posedge clk); #1;
        rx_valid = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic wait_frame();
        int n = 0;
        while ((tx_q.size() != 0 || busy) && n < 3000) begin
            @(posedge clk); #1;
            n++;
        end
        chk("frame_done", 32'(n < 3000), 32'(1));
        chk("tx_count", 32'(frame_tx_cnt), 32'(16));
        chk("ld_q_empty", 32'(ld_q.size()), 32'(0));
        chk("mvm_starts", 32'(start_cnt), 32'(exp_starts));
    endtask

    task automatic send_frame(input bit full, input logic [7:0] kseed, input logic [7:0] kstep,
                              input logic [7:0] xseed, input logic [7:0] xstep, input bit inject);
        ld_exp_t     e;
        logic [7:0]  b;
        logic [15:0] y;
        frame_tx_cnt = 0;
        send_byte(full ? 8'h01 : 8'h02);
        if (full) begin
            for (int i = 0; i < 32; i++) begin
                b = kseed + 8'(i) * kstep;
                k_ref[i*8 +: 8] = b;
                e.sel = 1'b0; e.addr = 5'(i); e.data = b;
                ld_q.push_back(e);
                send_byte(b);
            end
        end
        for (int i = 0; i < 4; i++) begin
            b = xseed + 8'(i) * xstep;
            x_ref[i*8 +: 8] = b;
            e.sel = 1'b1; e.addr = 5'(i); e.data = b;
            ld_q.push_back(e);
            send_byte(b);
        end
        exp_starts++;
        for (int r = 0; r < 8; r++) begin
            y = y_of(k_ref, x_ref, r);
            tx_q.push_back(y[7:0]);
            tx_q.push_back(y[15:8]);
        end
        if (inject) begin
            // Controller is now waiting on mvm_done
            chk("ovr_before", 32'(ovr), 32'(0));
            rx_valid = 1'b1;
            rx_data  = 8'h55;
            @(posedge clk); #1;
            rx_valid = 1'b0;
            chk("ovr_set", 32'(ovr), 32'(1));
            chk("ovr_busy", 32'(busy), 32'(1));
            chk("ovr_no_ld", 32'(ld_valid), 32'(0));
        end
        wait_frame();
    endtask

    initial begin
        ld_exp_t e;
        rst        = 1'b1;
        rx_valid   = 1'b0;
        rx_data    = 8'h00;
        stray_done = 1'b0;
        k_ref = '0; k_cap = '0; x_ref = '0; x_cap = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", 32'(busy), 32'(0));
        chk("rst_err", 32'(err), 32'(0));
        chk("rst_ovr", 32'(ovr), 32'(0));
        chk("rst_ld_valid", 32'(ld_valid), 32'(0));
        chk("rst_ld_sel", 32'(ld_sel), 32'(0));
        chk("rst_ld_addr", 32'(ld_addr), 32'(0));
        chk("rst_ld_data", 32'(ld_data), 32'(0));
        chk("rst_start", 32'(mvm_start), 32'(0));
        chk("rst_tx_valid", 32'(tx_valid), 32'(0));
        chk("rst_tx_data", 32'(tx_data), 32'(0));
        chk("rst_y_addr", 32'(y_addr), 32'(0));
        rst = 1'b0;
        @(posedge clk); #1;

        // Full frame, all nibbles 1 -> y = 8
        send_frame(1'b1, 8'h11, 8'h00, 8'h11, 8'h00, 1'b0);
        // X only, K unchanged, x nibbles 2 -> y = 16
        send_frame(1'b0, 8'h00, 8'h00, 8'h22, 8'h00, 1'b0);

        // Stray mvm_done in IDLE does nothing
        stray_done = 1'b1;
        @(posedge clk); #1;
        stray_done = 1'b0;
        @(posedge clk); #1;
        chk("stray_done_busy", 32'(busy), 32'(0));
        chk("stray_done_tx", 32'(tx_valid), 32'(0));

        // Unknown command
        send_byte(8'h7F);
        chk("unk_err", 32'(err), 32'(1));
        chk("unk_busy", 32'(busy), 32'(0));
        send_frame(1'b0, 8'h00, 8'h00, 8'h3A, 8'h11, 1'b0);
        chk("err_sticky", 32'(err), 32'(1));

        // Backpressure on byte 3 with varied operands
        bp_arm = 1'b1;
        send_frame(1'b1, 8'h9C, 8'h25, 8'hF7, 8'h3B, 1'b0);
        chk("bp_consumed", 32'(bp_arm), 32'(0));

        // Reset after 10 K bytes, with a command byte coincident with rst
        send_byte(8'h01);
        for (int i = 0; i < 10; i++) begin
            e.sel = 1'b0; e.addr = 5'(i); e.data = 8'(8'h40 + i);
            ld_q.push_back(e);
            send_byte(e.data);
        end
        rst      = 1'b1;
        rx_valid = 1'b1;
        rx_data  = 8'h01;
        @(posedge clk); #1;
        rst      = 1'b0;
        rx_valid = 1'b0;
        chk("mid_rst_busy", 32'(busy), 32'(0));
        chk("mid_rst_ld_valid", 32'(ld_valid), 32'(0));
        chk("mid_rst_err", 32'(err), 32'(0));
        @(posedge clk); #1;
        chk("rst_cmd_ignored", 32'(busy), 32'(0));
        chk("mid_rst_ld_q", 32'(ld_q.size()), 32'(0));
        send_frame(1'b1, 8'h5E, 8'h13, 8'h21, 8'h47, 1'b0);

        // Stray byte while waiting on the multiplier
        send_frame(1'b0, 8'h00, 8'h00, 8'h12, 8'h24, 1'b1);
        chk("ovr_sticky", 32'(ovr), 32'(1));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
